// File: rtl/wb_master_txn_engine_pkg.sv
// Shared types, state encodings and default widths for the Wishbone master
// transaction engine and its timeout counter.
package wb_master_txn_engine_pkg;

  localparam int WB_ADDR_WIDTH_DEF = 12;
  localparam int WB_DATA_WIDTH_DEF = 32;
  localparam int WB_MAX_BURST_DEF  = 16;
  localparam int WB_TIMEOUT_DEF    = 256;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WDAT = 2'd1,
    BUS  = 2'd2,
    RSP  = 2'd3
  } wb_txn_state_e;

  // Plain-vector views of the state encoding for the engine's state register
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WDAT = 2'd1;
  localparam logic [1:0] ST_BUS  = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  typedef struct packed {
    logic                                 we;
    logic [WB_ADDR_WIDTH_DEF-1:0]         adr;
    logic [WB_DATA_WIDTH_DEF/8-1:0]       sel;
    logic [$clog2(WB_MAX_BURST_DEF)-1:0]  len;
  } wb_cmd_s;

  typedef struct packed {
    logic [WB_DATA_WIDTH_DEF-1:0] dat;
    logic                         err;
    logic                         timeout;
    logic                         last;
  } wb_rsp_s;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-hang watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYCLES-1.
module wb_timeout_ctr
  import wb_master_txn_engine_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expire_o = (cnt_q == CNT_LAST);

  // Next count: saturates at the expiry value so it never wraps back to 0
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_master_txn_engine.sv
// Wishbone classic master: turns command/write-data streams into single or
// incrementing-burst bus cycles and returns one response per beat.
module wb_master_txn_engine
  import wb_master_txn_engine_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH_DEF,
  parameter int MAX_BURST      = WB_MAX_BURST_DEF,
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEF
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [ADDR_WIDTH-1:0]         cmd_adr,
  input  logic [DATA_WIDTH/8-1:0]       cmd_sel,
  input  logic [$clog2(MAX_BURST)-1:0]  cmd_len,
  input  logic                          wd_valid,
  output logic                          wd_ready,
  input  logic [DATA_WIDTH-1:0]         wd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_dat,
  output logic                          rsp_err,
  output logic                          rsp_timeout,
  output logic                          rsp_last,
  output logic [ADDR_WIDTH-3:0]         wb_adr_o,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  output logic [DATA_WIDTH/8-1:0]       wb_sel_o,
  output logic                          wb_we_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i
);

  localparam int AW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;
  localparam int LW = $clog2(MAX_BURST);

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         adr_q, adr_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         beat_q, beat_d;
  logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  tmo_expire_s;
  logic                  adr_lsb_unused;

  // Byte-lane bits of the command address are implied by word alignment
  assign adr_lsb_unused = ^cmd_adr[1:0];

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (state_q != ST_BUS),
    .en_i     (state_q == ST_BUS),
    .expire_o (tmo_expire_s)
  );

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wd_ready    = (state_q == ST_WDAT);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_last    = rsp_last_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_o_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;

  // Transaction FSM next-state and output-register logic
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    adr_d         = adr_q;
    sel_d         = sel_q;
    len_d         = len_q;
    beat_d        = beat_q;
    dat_o_d       = dat_o_q;
    cyc_d         = cyc_q;
    stb_d         = stb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_dat_d     = rsp_dat_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_last_d    = rsp_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr[ADDR_WIDTH-1:2];
          sel_d   = cmd_sel;
          len_d   = cmd_len;
          beat_d  = '0;
          cyc_d   = 1'b1;
          stb_d   = !cmd_we;
          state_d = cmd_we ? ST_WDAT : ST_BUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDAT: begin
        if (wd_valid) begin
          dat_o_d = wd_data;
          stb_d   = 1'b1;
          state_d = ST_BUS;
        end else begin
          state_d = ST_WDAT;
        end
      end
      ST_BUS: begin
        // err outranks ack; a terminated command releases the bus at once
        if (wb_err_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_dat_d   = '0;
          state_d     = ST_RSP;
        end else if (wb_ack_i) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : wb_dat_i;
          rsp_last_d  = (beat_q == len_q);
          state_d     = ST_RSP;
        end else if (tmo_expire_s) begin
          cyc_d         = 1'b0;
          stb_d         = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_last_d    = 1'b1;
          rsp_dat_d     = '0;
          state_d       = ST_RSP;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_dat_d     = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_last_d    = 1'b0;
          if (rsp_last_q) begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            beat_d  = beat_q + LW'(1);
            adr_d   = adr_q + AW'(1);
            stb_d   = !we_q;
            state_d = we_q ? ST_WDAT : ST_BUS;
          end
        end else begin
          state_d = ST_RSP;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any bus cycle in flight
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      adr_q         <= '0;
      sel_q         <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      dat_o_q       <= '0;
      cyc_q         <= 1'b0;
      stb_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_dat_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      sel_q         <= sel_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      dat_o_q       <= dat_o_d;
      cyc_q         <= cyc_d;
      stb_q         <= stb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_dat_q     <= rsp_dat_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_last_q    <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_wb_master_txn_engine.sv
// Randomized scoreboard bench for wb_master_txn_engine with a Wishbone slave
// model and a transaction-level reference memory.
module tb_wb_master_txn_engine;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MB = 16;
  localparam int TO = 8;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
    logic        last;
    logic        chk_dat;
  } exp_rsp_t;

  typedef struct packed {
    logic [9:0]  adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_bus_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [11:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [3:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout, rsp_last;
  logic [31:0] rsp_dat;
  logic [9:0]  wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;

  wb_master_txn_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_last(rsp_last),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] slv_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  exp_rsp_t    exp_q[$];
  exp_bus_t    bus_q[$];
  logic [31:0] wv_q[$];

  logic        cur_we;
  logic [11:0] cur_adr;
  logic [3:0]  cur_sel;
  logic [3:0]  cur_len;
  int wd_idx, wd_need;
  int slv_beat, slv_ws, plan_err, plan_hang, stray;
  bit slv_done;
  int rsp_beat_idx = 0;
  int stall_beat = -1;
  int stall_left = 0;
  bit rsp_rand = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: expand one command into expected bus beats and responses
  task automatic prep_cmd(input logic we, input logic [11:0] adr, input logic [3:0] sel,
                          input int len, input int ws, input int err_b, input int hang_b);
    exp_rsp_t r;
    exp_bus_t b;
    logic [9:0] base;
    logic [9:0] a;
    base = adr[11:2];
    if (wv_q.size() == 0) for (int i = 0; i <= len; i++) wv_q.push_back($urandom);
    wd_idx = 0;
    wd_need = 0;
    for (int i = 0; i <= len; i++) begin
      a = base + 10'(i);
      if (we) wd_need = i + 1;
      r = '{dat: 32'h0, err: 1'b0, tmo: 1'b0, last: (i == len), chk_dat: 1'b1};
      if (i == err_b) begin
        r.err = 1'b1; r.last = 1'b1; r.chk_dat = 1'b0;
        exp_q.push_back(r);
        break;
      end
      if (i == hang_b) begin
        r.tmo = 1'b1; r.last = 1'b1; r.chk_dat = 1'b0;
        exp_q.push_back(r);
        break;
      end
      b = '{adr: a, we: we, sel: sel, dat: (we ? wv_q[i] : 32'h0)};
      bus_q.push_back(b);
      if (we) ref_mem[a] = merge(ref_mem[a], wv_q[i], sel);
      else r.dat = ref_mem[a];
      exp_q.push_back(r);
    end
    cur_we = we; cur_adr = adr; cur_sel = sel; cur_len = 4'(len);
    slv_beat = 0; slv_done = 0; slv_ws = ws;
    plan_err = err_b; plan_hang = hang_b; stray = 0; rsp_beat_idx = 0;
  endtask

  task automatic send_cmd();
    bit hs;
    int n;
    hs = 0;
    n = 0;
    cmd_valid = 1'b1; cmd_we = cur_we; cmd_adr = cur_adr; cmd_sel = cur_sel; cmd_len = cur_len;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    cmd_we = 1'($urandom); cmd_adr = 12'($urandom); cmd_sel = 4'($urandom); cmd_len = 4'($urandom);
    check("cmd_accept", hs, 1);
  endtask

  task automatic finish_cmd(input bit strict_cyc);
    bit done;
    int n;
    done = 0;
    n = 0;
    while (!done && n < 3000) begin
      wd_valid = (wd_idx < wv_q.size()) && ($urandom_range(0, 3) != 0);
      wd_data  = (wd_idx < wv_q.size()) ? wv_q[wd_idx] : 32'h0;
      @(negedge clk);
      if (wd_valid && wd_ready) wd_idx++;
      if (cmd_ready) done = 1;
      else if (strict_cyc) check("cyc_held_in_burst", wb_cyc_o, 1);
      @(posedge clk); #1;
      n++;
    end
    wd_valid = 1'b0;
    if (!done) fail("cmd_completion_timeout");
    check("rsp_q_drained", exp_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);
    check("wd_beats_taken", wd_idx, wd_need);
    check("no_stb_after_term", stray, 0);
    check("cyc_low_idle", wb_cyc_o, 0);
    wv_q.delete();
  endtask

  // Wishbone slave: wait states, planned err/hang beats, glitches outside cycles
  initial begin
    int ws_cnt, stb_run;
    bit hang_active;
    exp_bus_t b;
    ws_cnt = 0; stb_run = 0; hang_active = 0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        ws_cnt = 0; stb_run = 0; hang_active = 0;
      end else if (wb_cyc_o && wb_stb_o) begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        if (slv_done) stray++;
        stb_run++;
        if (slv_beat == plan_hang) begin
          hang_active = 1;
        end else if (ws_cnt < slv_ws) begin
          ws_cnt++;
        end else if (slv_beat == plan_err) begin
          wb_err_i = 1'b1; wb_dat_i = $urandom;
          slv_done = 1; slv_beat++;
        end else begin
          wb_ack_i = 1'b1;
          if (bus_q.size() == 0) begin
            fail("bus_beat_unexpected");
          end else begin
            b = bus_q.pop_front();
            check("bus_adr", wb_adr_o, b.adr);
            check("bus_we", wb_we_o, b.we);
            check("bus_sel", wb_sel_o, b.sel);
            if (b.we) check("bus_dat", wb_dat_o, b.dat);
          end
          if (wb_we_o) begin
            slv_mem[wb_adr_o] = merge(slv_mem[wb_adr_o], wb_dat_o, wb_sel_o);
            wb_dat_i = $urandom;
          end else begin
            wb_dat_i = slv_mem[wb_adr_o];
          end
          slv_beat++;
        end
      end else begin
        wb_ack_i = ($urandom_range(0, 7) == 0);
        wb_err_i = ($urandom_range(0, 11) == 0);
        wb_dat_i = $urandom;
        if (hang_active) begin
          check("timeout_stb_cycles", stb_run, TO);
          hang_active = 0;
          slv_done = 1;
        end
        ws_cnt = 0;
        stb_run = 0;
      end
    end
  end

  // Response consumer: random or steady ready, with an optional directed stall
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0 && rsp_valid && rsp_beat_idx == stall_beat) begin
        rsp_ready = 1'b0;
        stall_left--;
      end else begin
        rsp_ready = rsp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks stability
  initial begin
    bit held;
    logic [35:0] saved;
    exp_rsp_t e;
    held = 0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) check("rsp_stable", {rsp_valid, rsp_dat, rsp_err, rsp_timeout, rsp_last}, saved);
        held = 0;
        if (rsp_valid) begin
          check("rsp_stb_low", wb_stb_o, 0);
          check("rsp_cyc_state", wb_cyc_o, !(rsp_err || rsp_timeout));
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              fail("rsp_unexpected");
            end else begin
              e = exp_q.pop_front();
              if (e.chk_dat) check("rsp_dat", rsp_dat, e.dat);
              check("rsp_err", rsp_err, e.err);
              check("rsp_timeout", rsp_timeout, e.tmo);
              check("rsp_last", rsp_last, e.last);
            end
            rsp_beat_idx++;
          end else begin
            held = 1;
            saved = {rsp_valid, rsp_dat, rsp_err, rsp_timeout, rsp_last};
          end
        end
      end
    end
  end

  initial begin
    int len, f, eb, hb;
    logic [9:0] w;
    logic [31:0] v;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 12'h0; cmd_sel = 4'h0; cmd_len = 4'h0;
    wd_valid = 1'b0; wd_data = 32'h0;
    plan_err = -1; plan_hang = -1; slv_ws = 0; slv_beat = 0; slv_done = 1; stray = 0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_wd_ready", wd_ready, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single read, 3 wait states
    slv_mem[10'h012] = 32'hDEADBEEF;
    ref_mem[10'h012] = 32'hDEADBEEF;
    prep_cmd(1'b0, 12'h048, 4'hF, 0, 3, -1, -1);
    send_cmd();
    finish_cmd(1'b1);

    // write burst with fixed data
    wv_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    prep_cmd(1'b1, 12'h400, 4'hF, 3, 1, -1, -1);
    send_cmd();
    finish_cmd(1'b1);

    // read burst with a 5-cycle response stall on beat 2
    stall_beat = 2;
    stall_left = 5;
    prep_cmd(1'b0, 12'h200, 4'hF, 7, 0, -1, -1);
    send_cmd();
    finish_cmd(1'b1);
    check("stall_applied", stall_left, 0);
    stall_beat = -1;

    // read burst terminated by err on beat 1
    prep_cmd(1'b0, 12'h300, 4'h3, 3, 1, 1, -1);
    send_cmd();
    finish_cmd(1'b0);

    // slave never answers
    prep_cmd(1'b0, 12'h0A0, 4'hF, 0, 0, -1, 0);
    send_cmd();
    finish_cmd(1'b0);

    // asynchronous reset in the middle of a burst
    rsp_rand = 1;
    prep_cmd(1'b0, 12'h100, 4'hF, 7, 1, -1, -1);
    send_cmd();
    repeat (6) @(posedge clk);
    #2;
    check("pre_rst_cyc", wb_cyc_o, 1);
    rst = 1'b1;
    #1;
    check("async_rst_cyc", wb_cyc_o, 0);
    check("async_rst_stb", wb_stb_o, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    exp_q.delete();
    bus_q.delete();
    wv_q.delete();
    slv_done = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);
    @(posedge clk); #1;

    // word-address wrap
    rsp_rand = 0;
    prep_cmd(1'b0, 12'hFFC, 4'hF, 1, 0, -1, -1);
    send_cmd();
    finish_cmd(1'b1);

    // randomized commands
    rsp_rand = 1;
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 15);
      f = $urandom_range(0, 9);
      eb = -1;
      hb = -1;
      if (f == 0) eb = $urandom_range(0, len);
      else if (f == 1) hb = $urandom_range(0, len);
      w = 10'($urandom);
      prep_cmd(1'($urandom_range(0, 1)), {w, 2'b00}, 4'($urandom_range(1, 15)),
               len, $urandom_range(0, 3), eb, hb);
      send_cmd();
      finish_cmd(1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_master_txn_engine.md
Name: wb_master_txn_engine

Overview:
Synthesizable, parametrised Wishbone classic master that turns valid/ready command and write-data streams into single or incrementing-burst bus cycles, and returns per-beat responses on a valid/ready stream.
It replaces the task-level read/write driver for emulation-friendly stimulus of the ethmac register and buffer-descriptor slave.
New capabilities: bursts, back-pressure on responses, error termination, and a bus-hang timeout.

Parameters:
ADDR_WIDTH, 12, byte-address width on cmd_adr; bus word address is cmd_adr[ADDR_WIDTH-1:2]
DATA_WIDTH, 32, Wishbone data width; must be 32 or 64
MAX_BURST, 16, maximum beats per command; must be a power of 2 and >= 2
TIMEOUT_CYCLES, 256, cycles with stb high and no ack/err before a timeout is declared; must be >= 2

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset: asynchronous assertion, active-high
cmd_valid  in  1  command valid
cmd_ready  out  1  engine accepts a command
cmd_we  in  1  1=write (WRITE), 0=read (READ)
cmd_adr  in  ADDR_WIDTH  start byte address, word-aligned
cmd_sel  in  DATA_WIDTH/8  byte selects, applied to every beat
cmd_len  in  $clog2(MAX_BURST)  number of beats minus 1
wd_valid  in  1  write beat data valid
wd_ready  out  1  write beat data accepted
wd_data  in  DATA_WIDTH  write beat data
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response consumer ready
rsp_dat  out  DATA_WIDTH  read data captured from wb_dat_i; 0 for writes
rsp_err  out  1  beat terminated by wb_err_i
rsp_timeout  out  1  beat terminated by timeout
rsp_last  out  1  final response beat of the command
wb_adr_o  out  ADDR_WIDTH-2  word address
wb_dat_o  out  DATA_WIDTH  write data
wb_dat_i  in  DATA_WIDTH  read data
wb_sel_o  out  DATA_WIDTH/8  byte selects
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; all counters 0.
  - cyc, stb, we, rsp_valid, rsp_err, rsp_timeout, rsp_last, wd_ready = 0.
  - adr, sel, dat_o, rsp_dat = 0.
  - Any in-flight bus cycle is dropped; no response is produced for it.
- States: IDLE, WDAT, BUS, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch we/adr/sel/len and set beat=0.
  - Next state: WDAT if we, else BUS with cyc=stb=1 from the next cycle.
- WDAT:
  - cyc=1, stb=0, wd_ready=1.
  - On wd_valid, latch wd_data into wb_dat_o and go to BUS.
  - The timeout counter does not run in WDAT.
- BUS:
  - cyc=stb=1; the timeout counter increments each cycle.
  - err has priority over ack when both are sampled on the same edge.
  - On sampled wb_ack_i: capture rsp_dat (reads only), stb=0, go to RSP.
  - On sampled wb_err_i: rsp_err=1, force rsp_last=1, cyc=stb=0, go to RSP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ack/err: rsp_timeout=1, rsp_last=1, cyc=stb=0, go to RSP.
  - The counter clears on every BUS entry.
- RSP:
  - rsp_valid=1; outputs are held stable until rsp_ready.
  - cyc stays 1 between beats of a non-terminated burst.
  - On rsp_ready:
    - If the beat is last (beat==len, err, or timeout): cyc=0, go to IDLE.
    - Otherwise: beat+1, wb_adr_o+1 (wraps modulo 2^(ADDR_WIDTH-2)), then go to WDAT for writes or BUS for reads.
- Latency:
  - Command handshake at edge N -> stb high after N (reads).
  - Ack sampled at edge M -> rsp_valid high after M.
  - With rsp_ready tied high, a read beat occupies 2 cycles plus slave wait states.
- wb_we_o is constant for the whole command. wb_sel_o = cmd_sel for all beats.
- cmd_ready=0 in every state except IDLE; a new command cannot overlap an old one.
- Any wb_ack_i/wb_err_i outside BUS is ignored.

Decomposition:
- wishbone_package gains:
  - wb_txn_state_e (IDLE, WDAT, BUS, RSP).
  - READ/WRITE constants (existing).
  - typedef wb_cmd_s {we, adr, sel, len}.
  - typedef wb_rsp_s {dat, err, timeout, last}.
  - Default-width localparams.
- One sub-module, wb_timeout_ctr: clear/enable/expire counter sized $clog2(TIMEOUT_CYCLES). The FSM stays in the top module.

Test Plan:
- Single read, adr=0x048, len=0; slave acks after 3 wait states with 0xDEADBEEF -> one response: rsp_dat=0xDEADBEEF, last=1, err=0; wb_adr_o=0x012; cyc drops after the rsp handshake.
- Write burst, adr=0x400, len=3; wd data 0x11,0x22,0x33,0x44 -> wb_adr_o sequence 0x100..0x103 with matching dat_o; 4 responses, last on beat 3; cyc continuous across beats.
- Read burst len=7 with rsp_ready low for 5 cycles at beat 2 -> stb low and cyc high during the stall; rsp fields stable; all 8 beats delivered in order.
- Slave asserts err on beat 1 of a len=3 read burst -> beat 1 response has err=1, last=1; no further stb; returns to IDLE.
- Slave never acks, TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles; rsp_timeout=1, last=1; cyc=0.
- Reset asserted mid-burst asynchronously -> cyc/stb/rsp_valid drop without waiting for a clock edge; cmd_ready=1 after release; next command runs normally; wrap check: adr=0xFFC len=1 gives wb_adr_o 0x3FF then 0x000.
